// File: rtl/sp_ram_banked.sv
// Single-port banked data RAM with req/gnt/rvalid handshake and per-bank idle
// retention sleep; a sleeping bank is woken on access and stalls the grant meanwhile.
module sp_ram_banked #(
   parameter int unsigned RAM_SIZE    = 32768,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned NUM_BANKS   = 4,
   parameter int unsigned IDLE_CYCLES = 64,
   parameter int unsigned WAKE_CYCLES = 2,
   parameter int unsigned ADDR_WIDTH  = $clog2(RAM_SIZE)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_i,
   output logic                      gnt_o,
   input  logic [ADDR_WIDTH-1:0]     addr_i,
   input  logic                      we_i,
   input  logic [DATA_WIDTH/8-1:0]   be_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   output logic                      rvalid_o,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   input  logic                      sleep_en_i,
   output logic [NUM_BANKS-1:0]      bank_sleep_o
);

   localparam int unsigned NumBytes = DATA_WIDTH / 8;
   localparam int unsigned ByteOffW = $clog2(NumBytes);
   localparam int unsigned WordW    = ADDR_WIDTH - ByteOffW;
   localparam int unsigned BankBits = $clog2(NUM_BANKS);
   localparam int unsigned BankW    = (BankBits > 0) ? BankBits : 1;
   localparam int unsigned OffW     = WordW - BankBits;
   localparam int unsigned Depth    = RAM_SIZE / (NUM_BANKS * NumBytes);
   localparam int unsigned IdleW    = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam int unsigned IdleMax  = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
   localparam int unsigned WakeW    = $clog2(WAKE_CYCLES + 1);

   typedef enum logic [1:0] {StActive, StSleep, StWake} bank_state_e;

   logic [WordW-1:0]                      word_idx;
   logic [OffW-1:0]                       word_off;
   logic [BankW-1:0]                      bank_sel;
   logic [NUM_BANKS-1:0]                  bank_active;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  bank_rdata;
   logic                                  rvalid_d, rvalid_q;
   logic [BankW-1:0]                      rbank_d, rbank_q;

   assign word_idx = addr_i[ADDR_WIDTH-1:ByteOffW];
   assign word_off = word_idx[OffW-1:0];

   if (BankBits > 0) begin : g_bank_sel
      assign bank_sel = word_idx[WordW-1:OffW];
   end else begin : g_single_bank
      assign bank_sel = '0;
   end

   if (ByteOffW > 0) begin : g_unused_offs
      logic unused_byte_off;
      assign unused_byte_off = ^addr_i[ByteOffW-1:0];
   end

   assign gnt_o = req_i & bank_active[bank_sel];

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      bank_state_e            state_d, state_q;
      logic [IdleW-1:0]       idle_d, idle_q;
      logic [WakeW-1:0]       wake_d, wake_q;
      logic [DATA_WIDTH-1:0]  rd_d, rd_q;
      logic [DATA_WIDTH-1:0]  mem_q [Depth];
      logic                   hit, acc;

      assign hit = req_i && (bank_sel == BankW'(b));
      assign acc = hit && (state_q == StActive);

      always_comb begin
         state_d = state_q;
         idle_d  = idle_q;
         wake_d  = wake_q;
         rd_d    = rd_q;
         unique case (state_q)
            StActive: begin
               if (acc || !sleep_en_i) begin
                  idle_d = '0;
               end else if (IDLE_CYCLES != 0) begin
                  if (idle_q == IdleW'(IdleMax)) begin
                     state_d = StSleep;
                     idle_d  = '0;
                  end else begin
                     idle_d = idle_q + IdleW'(1);
                  end
               end
            end
            StSleep: begin
               if (hit) begin
                  state_d = StWake;
                  wake_d  = WakeW'(WAKE_CYCLES);
               end
            end
            StWake: begin
               if (wake_q == WakeW'(1)) begin
                  state_d = StActive;
               end else begin
                  wake_d = wake_q - WakeW'(1);
               end
            end
            default: state_d = StActive;
         endcase
         if (acc && !we_i) begin
            rd_d = mem_q[word_off];
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q <= StActive;
            idle_q  <= '0;
            wake_q  <= '0;
            rd_q    <= '0;
         end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
            rd_q    <= rd_d;
         end
      end

      // Storage is never reset so contents survive both sleep and reset.
      always_ff @(posedge clk) begin
         if (acc && we_i) begin
            for (int i = 0; i < NumBytes; i++) begin
               if (be_i[i]) begin
                  mem_q[word_off][i*8 +: 8] <= wdata_i[i*8 +: 8];
               end
            end
         end
      end

      assign bank_active[b]  = (state_q == StActive);
      assign bank_sleep_o[b] = (state_q == StSleep);
      assign bank_rdata[b]   = rd_q;
   end

   always_comb begin
      rvalid_d = gnt_o;
      rbank_d  = rbank_q;
      if (gnt_o && !we_i) begin
         rbank_d = bank_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         rbank_q  <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         rbank_q  <= rbank_d;
      end
   end

   assign rvalid_o = rvalid_q;
   // Only the last-read bank's register moves on a read, so rdata_o holds across writes.
   assign rdata_o  = bank_rdata[rbank_q];

endmodule

// File: doc/sp_ram_banked.md
# sp_ram_banked

Parametrised single-port banked data RAM for the PULPino memory subsystem: replaces the fixed four-bank SRAM wrapper with a configurable bank count and word width. Adds a request/grant/rvalid handshake and per-bank idle power management. An idle bank drops into retention sleep and is woken transparently on the next access, stalling the grant while it wakes. Contents are retained across sleep.

## Interface
- RAM_SIZE, 32768: total capacity in bytes; power of two.
- DATA_WIDTH, 32: word width in bits; multiple of 8.
- NUM_BANKS, 4: bank count; power of two, at least 1.
- IDLE_CYCLES, 64: consecutive idle cycles before a bank sleeps; 0 disables sleep.
- WAKE_CYCLES, 2: cycles a bank spends in WAKE before it can be granted; at least 1.
- ADDR_WIDTH, $clog2(RAM_SIZE): derived byte-address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_i  in  1  access request; addr_i, we_i, be_i and wdata_i are held stable until gnt_o.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  ADDR_WIDTH  byte address; word index = addr_i[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]; bank = top $clog2(NUM_BANKS) bits of the word index.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  DATA_WIDTH/8  byte enables; writes only.
- wdata_i  in  DATA_WIDTH  write data.
- rvalid_o  out  1  response for the access granted in the previous cycle.
- rdata_o  out  DATA_WIDTH  read data; valid when rvalid_o=1 and the access was a read.
- sleep_en_i  in  1  enables idle sleep entry.
- bank_sleep_o  out  NUM_BANKS  per-bank 1 = SLEEP state (retention).

## Operation
- Each bank holds RAM_SIZE/NUM_BANKS bytes as a behavioural word array with byte-write granularity. Contents are not reset.
- Per-bank FSM with three states.
  - ACTIVE: normal operation.
  - SLEEP: no access possible; bank_sleep_o[b]=1.
  - WAKE: counts WAKE_CYCLES down, then goes to ACTIVE.
- gnt_o = req_i AND (target bank is ACTIVE). This is combinational from the current state.
- Accepted write: each byte with be_i set is written at the granting edge; other bytes are unchanged.
- Accepted read: data comes from the target bank. The bank index is registered, and the output mux selects the registered bank.
- ACTIVE -> SLEEP: the idle counter increments on each ACTIVE cycle with sleep_en_i=1 and no accepted access to that bank.
  - When the counter equals IDLE_CYCLES-1 under those same conditions, the bank goes to SLEEP and the counter clears.
  - The counter clears on any accepted access to the bank, or whenever sleep_en_i=0.
  - When IDLE_CYCLES=0 the bank never sleeps.
- SLEEP -> WAKE: happens on any cycle where req_i=1 targets the bank. The wake counter loads WAKE_CYCLES.
- WAKE -> ACTIVE: happens when the wake counter reaches 1 at the edge. gnt_o stays 0 throughout WAKE.
- sleep_en_i=0 blocks new sleep entry only. Sleeping banks wake solely on access.
- Only the addressed bank changes state due to a request. Other banks continue their own idle counting.

## Timing
- Reset (rst_n=0 at an edge) puts every output to 0: gnt_o, rvalid_o, rdata_o and bank_sleep_o. All banks go to ACTIVE and all counters clear. Reset during WAKE or SLEEP returns the bank to ACTIVE.
- Active-bank access: request and grant in cycle t; rvalid_o=1 in t+1. For a read, rdata_o carries the data in t+1.
- Back-to-back accesses sustain one per cycle to any ACTIVE banks.
- Write response: rvalid_o=1 in t+1 and rdata_o holds its previous value.
- rdata_o holds its value until the next read response.
- Read-after-write to the same address in the next cycle returns the new data.
- Sleeping-bank access, with req_i first seen in cycle t:
  - The bank is WAKE in cycles t+1 through t+WAKE_CYCLES.
  - The bank is ACTIVE and gnt_o=1 in t+WAKE_CYCLES+1.
  - rvalid_o=1 in t+WAKE_CYCLES+2.
- Sleep entry: after IDLE_CYCLES consecutive idle cycles with sleep_en_i=1, bank_sleep_o[b] rises in the next cycle.
- If an access lands in the cycle the counter would expire, the access wins: no sleep, and the counter clears.
- req_i deasserted during WAKE: the wake still completes and the bank becomes ACTIVE. No grant and no response are issued.

## Test plan
- Write then read, RAM_SIZE=32768, NUM_BANKS=4:
  - Cycle 0: write 0xDEADBEEF to 0x6004 with be=4'hF.
  - Cycle 1: read 0x6004.
  - Required: gnt in both cycles; rvalid in cycles 1 and 2; rdata=0xDEADBEEF in cycle 2. Bank 3 contents only.
- Byte enables:
  - Write 0x11223344 to 0x0000 with be=F, then write 0xAABBCCDD with be=4'b0101.
  - Required: a read of 0x0000 returns 0x11BB33DD.
- Sleep/wake, IDLE_CYCLES=4, WAKE_CYCLES=2, sleep_en_i=1:
  - Idle for 4 cycles. Required: bank_sleep_o=4'hF.
  - Read 0x2000 at cycle t. Required: gnt_o=0 at t, t+1 and t+2; gnt_o=1 at t+3; rvalid at t+4 with the retained data. Only bank_sleep_o[1] clears.
- Expiry collision:
  - Access bank 0 in exactly the 4th idle cycle.
  - Required: granted immediately, bank_sleep_o[0] stays 0, and the counter restarts.
- sleep_en_i=0 for 100 idle cycles:
  - Required: bank_sleep_o stays 0.
  - Re-enable sleep_en_i. Required: sleep occurs exactly IDLE_CYCLES cycles later.
- Reset mid-wake:
  - Assert rst_n=0 during WAKE.
  - Required: next cycle, all outputs are 0 and all banks are ACTIVE. A following read is granted the same cycle and returns the pre-reset contents.
